// File: rtl/grayscale_bin_averager_pkg.sv
// Shared constants and types for the grayscale bin averager: default capture geometry,
// bin sizes and the derived output geometry / accumulator widths.
package grayscale_bin_averager_pkg;

    localparam int DEFAULT_IMAGE_WIDTH  = 320;
    localparam int DEFAULT_IMAGE_HEIGHT = 240;
    localparam int DEFAULT_BIN_WIDTH    = 4;
    localparam int DEFAULT_BIN_HEIGHT   = 4;

    localparam int OUT_W = DEFAULT_IMAGE_WIDTH / DEFAULT_BIN_WIDTH;
    localparam int OUT_H = DEFAULT_IMAGE_HEIGHT / DEFAULT_BIN_HEIGHT;
    localparam int SHIFT = $clog2(DEFAULT_BIN_WIDTH * DEFAULT_BIN_HEIGHT);
    localparam int SUM_W = 8 + SHIFT;

    typedef logic [7:0] pixel_t;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/grayscale_bin_averager_if.sv
// Pixel stream port bundle: raster pixels from the ingester in, binned pixels to the stuffer out.
interface grayscale_bin_averager_if;
    import grayscale_bin_averager_pkg::*;

    logic   vsync_in;
    logic   data_in_valid;
    pixel_t data_in;
    logic   vsync_out;
    logic   data_out_valid;
    pixel_t data_out;

    modport master (
        output vsync_in, data_in_valid, data_in,
        input  vsync_out, data_out_valid, data_out
    );

    modport slave (
        input  vsync_in, data_in_valid, data_in,
        output vsync_out, data_out_valid, data_out
    );
endinterface

// File: rtl/grayscale_bin_averager_bin_line_ram.sv
// Per-column partial-sum store for the bin averager; single port, synchronous read, no reset (EBR).
// Latency: read data valid 1 clock after re. Backpressure: none, caller never reads and writes together.
// Write and read share addr; contents persist across frames and are masked by the caller on a bin's first row.
module bin_line_ram #(
    parameter int depth  = 80,
    parameter int width  = 12,
    parameter int addr_w = 7
) (
    input  logic              clock,
    input  logic [addr_w-1:0] addr,
    input  logic              we,
    input  logic [width-1:0]  wdata,
    input  logic              re,
    output logic [width-1:0]  rdata
);
    logic [width-1:0] mem [depth];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/grayscale_bin_averager.sv
// Block-mean downscaler: one output pixel per bin_width x bin_height block of a raster 8-bit stream.
// Latency: data_out_valid 1 clock after the bin's last pixel. Backpressure: none; strobes >= 2 clocks apart.
// GRAYSCALE_BIN_ROUND_EN selects saturating round-half-up instead of a truncating shift.
module grayscale_bin_averager
    import grayscale_bin_averager_pkg::*;
#(
    parameter int image_width  = DEFAULT_IMAGE_WIDTH,
    parameter int image_height = DEFAULT_IMAGE_HEIGHT,
    parameter int bin_width    = DEFAULT_BIN_WIDTH,
    parameter int bin_height   = DEFAULT_BIN_HEIGHT
) (
    input  logic clock,
    input  logic reset,
    grayscale_bin_averager_if.slave bus
);
    localparam int BW_LOG    = $clog2(bin_width);
    localparam int BH_LOG    = $clog2(bin_height);
    localparam int ACC_SHIFT = BW_LOG + BH_LOG;
    localparam int HACC_W    = 8 + BW_LOG;
    localparam int TOT_W     = 8 + ACC_SHIFT;
    localparam int N_COLS    = image_width / bin_width;
    localparam int COL_AW    = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int X_W       = (image_width > 1) ? $clog2(image_width) : 1;
    localparam int Y_W       = (image_height > 1) ? $clog2(image_height) : 1;

    localparam logic [X_W-1:0] X_MASK = X_W'(bin_width - 1);
    localparam logic [Y_W-1:0] Y_MASK = Y_W'(bin_height - 1);
    localparam logic [X_W-1:0] X_LAST = X_W'(image_width - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(image_height - 1);

    if (!is_pow2(bin_width) || bin_width < 2 || (image_width % bin_width) != 0) begin : g_bad_bin_width
        $error("grayscale_bin_averager: bin_width must be a power of two >= 2 dividing image_width");
    end
    if (!is_pow2(bin_height) || (image_height % bin_height) != 0) begin : g_bad_bin_height
        $error("grayscale_bin_averager: bin_height must be a power of two dividing image_height");
    end

    logic              seen_low;
    logic              frame_done;
    logic [X_W-1:0]    x_idx;
    logic [Y_W-1:0]    y_idx;
    logic [HACC_W-1:0] h_acc;
    logic [TOT_W-1:0]  ram_rdata;
    logic [TOT_W-1:0]  total;
    logic [COL_AW-1:0] bx;
    logic              pix, bin_first, bin_last, row_first, row_last;
    logic              ram_we, ram_re;
    pixel_t            avg;
    logic              vsync_q, out_vld;
    pixel_t            out_dat;

    // Pixels are only taken once a full vsync low->high has been seen since reset.
    assign pix       = bus.data_in_valid && bus.vsync_in && seen_low && !frame_done;
    assign bin_first = (x_idx & X_MASK) == '0;
    assign bin_last  = (x_idx & X_MASK) == X_MASK;
    assign row_first = (y_idx & Y_MASK) == '0;
    assign row_last  = (y_idx & Y_MASK) == Y_MASK;
    assign bx        = COL_AW'(x_idx >> BW_LOG);
    assign total     = TOT_W'(h_acc) + TOT_W'(bus.data_in) + (row_first ? '0 : ram_rdata);
    assign ram_re    = pix && bin_first;
    assign ram_we    = pix && bin_last && !row_last;

`ifdef GRAYSCALE_BIN_ROUND_EN
    localparam logic [TOT_W:0] HALF = (TOT_W + 1)'(1) << (ACC_SHIFT - 1);
    logic [TOT_W:0] rounded;
    assign rounded = {1'b0, total} + HALF;
    assign avg     = (|(rounded >> (ACC_SHIFT + 8))) ? 8'hFF : 8'(rounded >> ACC_SHIFT);
`else
    assign avg     = 8'(total >> ACC_SHIFT);
`endif

    bin_line_ram #(
        .depth  (N_COLS),
        .width  (TOT_W),
        .addr_w (COL_AW)
    ) u_line_ram (
        .clock (clock),
        .addr  (bx),
        .we    (ram_we),
        .wdata (total),
        .re    (ram_re),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            vsync_q    <= 1'b0;
            out_vld    <= 1'b0;
            out_dat    <= '0;
            seen_low   <= 1'b0;
            frame_done <= 1'b0;
            x_idx      <= '0;
            y_idx      <= '0;
            h_acc      <= '0;
        end else begin
            vsync_q <= bus.vsync_in;
            out_vld <= 1'b0;
            if (!bus.vsync_in) begin
                seen_low   <= 1'b1;
                frame_done <= 1'b0;
                x_idx      <= '0;
                y_idx      <= '0;
                h_acc      <= '0;
            end else if (pix) begin
                h_acc <= bin_first ? HACC_W'(bus.data_in) : h_acc + HACC_W'(bus.data_in);
                if (bin_last && row_last) begin
                    out_vld <= 1'b1;
                    out_dat <= avg;
                end
                if (x_idx == X_LAST) begin
                    x_idx <= '0;
                    // Saturate at the frame's last pixel; extra strobes are ignored until vsync falls.
                    if (y_idx == Y_LAST) begin
                        frame_done <= 1'b1;
                    end else begin
                        y_idx <= y_idx + Y_W'(1);
                    end
                end else begin
                    x_idx <= x_idx + X_W'(1);
                end
            end
        end
    end

    assign bus.vsync_out      = vsync_q;
    assign bus.data_out_valid = out_vld;
    assign bus.data_out       = out_dat;
endmodule
